encoder_scan_n: RTL and testbench



---
 rtl/encoder_scan_n.sv | 124 ++++++++++++
 tb/tb_encoder_scan_n.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_scan_n.sv
// encoder_scan_n: captures a multi-hot request vector and serves the index of
//   each set bit, one per valid/ready handshake, in priority order.
// Latency: first index is valid 1 cycle after load; one index per cycle with ready high.
// Backpressure: while ready=0, Yout and the pending set hold; load is ignored while busy.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   load, Xin     capture request (honoured only when idle) and request vector
//   Yout, valid   index currently offered and its qualifier
//   ready         consumer accepts Yout this cycle when valid=1
//   busy          high while scanning (equals valid)
//   zero, done    one-cycle pulses: empty vector loaded / last index accepted
module encoder_scan_n #(
  parameter int WIDTH     = 8,
  parameter int IDX_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] Xin,
  output logic [IDX_W-1:0] Yout,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] pend_left;

  // Priority select over the pending register. The loop direction makes the
  // last hit the winner, so the winning bit is the first one in scan order.
  // pend_q is zero whenever idle, so sel_idx is 0 there as well.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pend_q[i]) begin
          sel_idx     = IDX_W'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          sel_idx     = IDX_W'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end
  end

  assign pend_left = pend_q & ~sel_mask;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (|Xin) begin
            pend_d  = Xin;
            state_d = SCAN;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (ready) begin
          pend_d = pend_left;
          if (pend_left == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  // Every output decodes only registered state; nothing flows from Xin.
  assign Yout  = sel_idx;
  assign valid = (state_q == SCAN);
  assign busy  = (state_q == SCAN);
  assign zero  = zero_q;
  assign done  = done_q;

endmodule

// File: tb/tb_encoder_scan_n.sv
module tb_encoder_scan_n;

  logic        clk = 1'b0;
  logic        rst, load, load2, ready;
  logic [7:0]  xin8;
  logic [11:0] xin12;

  logic [2:0]  y0, y1;
  logic [3:0]  y2;
  logic        v0, v1, v2, b0, b1, b2, z0, z1, z2, d0, d1, d2;

  int total = 0;
  int bad   = 0;

  // Expected event streams: index >= 0, -1 = done pulse, -2 = zero pulse.
  int q0[$];
  int q1[$];
  int q2[$];

  always #5 clk = ~clk;

  encoder_scan_n #(.WIDTH(8), .IDX_W(3), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .load(load), .Xin(xin8), .Yout(y0), .valid(v0),
    .ready(ready), .busy(b0), .zero(z0), .done(d0));

  encoder_scan_n #(.WIDTH(8), .IDX_W(3), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .load(load), .Xin(xin8), .Yout(y1), .valid(v1),
    .ready(ready), .busy(b1), .zero(z1), .done(d1));

  encoder_scan_n #(.WIDTH(12), .IDX_W(4), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .load(load2), .Xin(xin12), .Yout(y2), .valid(v2),
    .ready(ready), .busy(b2), .zero(z2), .done(d2));

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int qfront(input int id);
    case (id)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int id);
    case (id)
      0:       q0.delete(0);
      1:       q1.delete(0);
      default: q2.delete(0);
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_pulse(input int id, input int code, input string nm);
    total++;
    if (qsize(id) == 0) begin
      bad++;
      $display("FAIL u%0d %s: unexpected pulse, expected nothing", id, nm);
    end else begin
      if (qfront(id) != code) begin
        bad++;
        $display("FAIL u%0d %s: got %s pulse, expected event %0d", id, nm, nm, qfront(id));
      end
      qpop(id);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic r, input logic d,
                     input logic z, input logic b, input logic [7:0] y);
    total++;
    if (b !== v || (v && (d || z)) || (d && z)) begin
      bad++;
      $display("FAIL u%0d flags: valid=%b busy=%b done=%b zero=%b, expected busy==valid, no overlap",
               id, v, b, d, z);
    end
    if (v === 1'b1) begin
      total++;
      if (qsize(id) == 0) begin
        bad++;
        $display("FAIL u%0d yout: got unexpected index %0d, expected nothing", id, y);
      end else begin
        if (int'(y) != qfront(id)) begin
          bad++;
          $display("FAIL u%0d yout: got %0d expected %0d", id, y, qfront(id));
        end
        if (r === 1'b1) qpop(id);
      end
    end
    if (d === 1'b1) expect_pulse(id, -1, "done");
    if (z === 1'b1) expect_pulse(id, -2, "zero");
  endtask

  // Monitor: samples on the falling edge, decoupled from stimulus.
  always @(negedge clk) begin
    mon(0, v0, ready, d0, z0, b0, {5'b0, y0});
    mon(1, v1, ready, d1, z1, b1, {5'b0, y1});
    mon(2, v2, ready, d2, z2, b2, {4'b0, y2});
  end

  // Called at posedge+1; returns at posedge+1 after the capturing edge.
  task automatic load8(input logic [7:0] v);
    load = 1'b1;
    xin8 = v;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    total++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      bad++;
      $display("FAIL drain: %0d/%0d/%0d events still pending, expected 0",
               q0.size(), q1.size(), q2.size());
      q0.delete(); q1.delete(); q2.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b0; load2 = 1'b0; ready = 1'b0;
    xin8 = '0; xin12 = '0;

    // Reset: two cycles, outputs all zero.
    @(posedge clk);
    @(negedge clk);
    chk("rst valid u0", {31'b0, v0}, 0);
    chk("rst yout u0", {29'b0, y0}, 0);
    chk("rst busy/zero/done u0", {29'b0, b0, z0, d0}, 0);
    chk("rst outs u1", {25'b0, y1, v1, b1, z1, d1}, 0);
    chk("rst outs u2", {24'b0, y2, v2, b2, z2, d2}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single bit: index 4, then done with valid low.
    ready = 1'b1;
    q0.push_back(4); q0.push_back(-1);
    q1.push_back(4); q1.push_back(-1);
    load8(8'b0001_0000);
    @(negedge clk);
    chk("single latency valid", {31'b0, v0}, 1);
    @(negedge clk);
    chk("single done/valid/busy", {29'b0, d0, v0, b0}, 3'b100);
    drain(20);

    // Multi-hot with backpressure for 3 cycles.
    ready = 1'b0;
    q0 = '{0, 2, 5, 7, -1};
    q1 = '{7, 5, 2, 0, -1};
    load8(8'b1010_0101);
    repeat (3) @(posedge clk);
    #1;
    ready = 1'b1;
    drain(30);

    // Zero vector: one zero pulse, nothing else.
    q0.push_back(-2);
    q1.push_back(-2);
    load8(8'h00);
    @(negedge clk);
    chk("zero pulse u0", {28'b0, z0, v0, b0, d0}, 4'b1000);
    drain(20);

    // All ones: exactly WIDTH handshakes then done.
    q0 = '{0, 1, 2, 3, 4, 5, 6, 7, -1};
    q1 = '{7, 6, 5, 4, 3, 2, 1, 0, -1};
    load8(8'hFF);
    drain(30);

    // Mid-scan load ignored; reload in the done cycle honoured.
    q0 = '{0, 1, -1, 7, -1};
    q1 = '{1, 0, -1, 7, -1};
    load = 1'b1; xin8 = 8'h03;
    @(posedge clk); #1;
    xin8 = 8'hF0;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    load = 1'b1; xin8 = 8'h80;
    @(negedge clk);
    chk("reload done cycle", {30'b0, d0, v0}, 2'b10);
    @(posedge clk); #1;
    load = 1'b0;
    drain(20);

    // WIDTH=12: reset after three accepts, then reload top bit.
    q2 = '{0, 1, 2, 3};
    load2 = 1'b1; xin12 = 12'hFFF;
    @(posedge clk); #1;
    load2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q2.delete();
    @(negedge clk);
    chk("w12 after rst valid/busy/done", {29'b0, v2, b2, d2}, 0);
    chk("w12 after rst yout", {28'b0, y2}, 0);
    @(negedge clk);
    chk("w12 no late done", {31'b0, d2}, 0);
    @(posedge clk); #1;
    ready = 1'b1;
    q2 = '{11, -1};
    load2 = 1'b1; xin12 = 12'h800;
    @(posedge clk); #1;
    load2 = 1'b0;
    @(negedge clk);
    chk("w12 top index", {28'b0, y2}, 11);
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
